board_move_writer: RTL and testbench

//   Move engine for the 4x4 2048 board: accepts a direction command, snapshots the 16 board cells,

---
 rtl/board_pkg.sv | 39 +++
 rtl/board_move_writer_if.sv | 29 ++
 rtl/board_move_writer_line_merge.sv | 59 +++++
 rtl/board_move_writer.sv | 125 ++++++++++++
 tb/tb_board_move_writer.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/board_pkg.sv
// Shared constants and types for the 2048 board move engine.
// Board cell (col,row) lives at flat index col*4+row.
package board_pkg;

   localparam int DATA_W   = 12;
   localparam int SCORE_W  = 20;
   localparam int MAX_TILE = 2048;

   typedef enum logic [1:0] {
      UP    = 2'd0,
      DOWN  = 2'd1,
      LEFT  = 2'd2,
      RIGHT = 2'd3
   } dir_t;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      COMPUTE = 3'd2,
      WRITE   = 3'd3,
      DONE    = 3'd4
   } state_t;

   function automatic logic [3:0] cellIdx(input logic [1:0] col, input logic [1:0] row);
      return {col, row};
   endfunction

   // Position 0 of a line is the edge the tiles slide toward.
   function automatic logic [3:0] linePos(input dir_t dir, input logic [1:0] line,
                                          input logic [1:0] pos);
      case (dir)
         UP:      return cellIdx(line, pos);
         DOWN:    return cellIdx(line, 2'd3 - pos);
         LEFT:    return cellIdx(pos, line);
         default: return cellIdx(2'd3 - pos, line);
      endcase
   endfunction

endpackage

// File: rtl/board_move_writer_if.sv
// Command, board snapshot and board-memory write bus of the move engine.
// slave = move engine side, master = controller/memory side.
interface board_move_writer_if #(
   parameter int DATA_W  = board_pkg::DATA_W,
   parameter int SCORE_W = board_pkg::SCORE_W
);
   logic                  mem_ready;
   logic                  move_valid;
   logic [1:0]            move_dir;
   logic                  move_ready;
   logic [16*DATA_W-1:0]  cells;
   logic                  wr;
   logic [1:0]            addr_col;
   logic [1:0]            addr_row;
   logic [DATA_W-1:0]     data_out;
   logic                  done;
   logic                  moved;
   logic [SCORE_W-1:0]    score;

   modport master (
      output mem_ready, move_valid, move_dir, cells,
      input  move_ready, wr, addr_col, addr_row, data_out, done, moved, score
   );

   modport slave (
      input  mem_ready, move_valid, move_dir, cells,
      output move_ready, wr, addr_col, addr_row, data_out, done, moved, score
   );
endinterface

// File: rtl/board_move_writer_line_merge.sv
// Combinational 2048 line slide: compact non-zeros toward index 0, then merge
// equal neighbours once each (no cascade); reports the sum of merged tiles.
module line_merge #(
   parameter int DATA_W   = board_pkg::DATA_W,
   parameter int MAX_TILE = board_pkg::MAX_TILE,
   parameter int SUM_W    = DATA_W + 2
) (
   input  logic [DATA_W-1:0] lineIn  [4],
   output logic [DATA_W-1:0] lineOut [4],
   output logic [SUM_W-1:0]  mergeSum
);

   logic [DATA_W-1:0] comp [4];
   logic [DATA_W-1:0] nxt  [4];
   logic [DATA_W-1:0] dbl;
   logic [1:0]        nIdx;
   logic [1:0]        oIdx;
   logic              skip;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         comp[i]    = '0;
         lineOut[i] = '0;
      end
      nIdx     = '0;
      oIdx     = '0;
      skip     = 1'b0;
      mergeSum = '0;
      dbl      = '0;

      for (int i = 0; i < 4; i++) begin
         if (lineIn[i] != '0) begin
            comp[nIdx] = lineIn[i];
            nIdx       = nIdx + 2'd1;
         end
      end

      for (int i = 0; i < 3; i++) nxt[i] = comp[i+1];
      nxt[3] = '0;

      // A merged pair consumes its partner, so the partner is skipped.
      for (int i = 0; i < 4; i++) begin
         if (skip) begin
            skip = 1'b0;
         end else if (comp[i] != '0) begin
            if (comp[i] == nxt[i] && comp[i] != DATA_W'(MAX_TILE)) begin
               dbl           = {comp[i][DATA_W-2:0], 1'b0};
               lineOut[oIdx] = dbl;
               mergeSum      = mergeSum + SUM_W'(dbl);
               skip          = 1'b1;
            end else begin
               lineOut[oIdx] = comp[i];
            end
            oIdx = oIdx + 2'd1;
         end
      end
   end

endmodule

// File: rtl/board_move_writer.sv
// 2048 move engine: snapshot board, slide/merge one line per cycle, write back
// all 16 cells column-major. Build macro SKIP_UNCHANGED_EN suppresses wr for unchanged cells.
module board_move_writer #(
   parameter int DATA_W   = board_pkg::DATA_W,
   parameter int MAX_TILE = board_pkg::MAX_TILE,
   parameter int SCORE_W  = board_pkg::SCORE_W
) (
   input logic               clk,
   input logic               rst_n,
   board_move_writer_if.slave bus
);
   import board_pkg::*;

   localparam int SUM_W = DATA_W + 2;

   state_t             state;
   state_t             stateNext;
   dir_t               dirQ;
   logic [3:0]         cnt;
   logic [SCORE_W-1:0] scoreQ;
   logic [DATA_W-1:0]  snap      [16];
   logic [DATA_W-1:0]  nextBoard [16];
   logic [DATA_W-1:0]  lineIn    [4];
   logic [DATA_W-1:0]  lineOut   [4];
   logic [SUM_W-1:0]   mergeSum;
   logic               anyChanged;
   logic               accept;

   function automatic logic [SCORE_W-1:0] satAdd(input logic [SCORE_W-1:0] a,
                                                 input logic [SUM_W-1:0]   b);
      logic [SCORE_W:0] s;
      s = {1'b0, a} + (SCORE_W+1)'(b);
      return s[SCORE_W] ? '1 : s[SCORE_W-1:0];
   endfunction

   assign accept = bus.move_valid && bus.move_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (accept) stateNext = LOAD;
         LOAD:    stateNext = COMPUTE;
         COMPUTE: if (cnt == 4'd3) stateNext = WRITE;
         WRITE:   if (cnt == 4'd15) stateNext = DONE;
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         dirQ   <= UP;
         scoreQ <= '0;
      end else begin
         if ((state == COMPUTE || state == WRITE) && stateNext == state) cnt <= cnt + 4'd1;
         else                                                             cnt <= '0;
         if (accept)           dirQ   <= dir_t'(bus.move_dir);
         if (state == COMPUTE) scoreQ <= satAdd(scoreQ, mergeSum);
      end
   end

   // Snapshot is taken only in LOAD; later changes on cells are ignored.
   always_ff @(posedge clk) begin
      if (state == LOAD) begin
         for (int i = 0; i < 16; i++) snap[i] <= bus.cells[i*DATA_W +: DATA_W];
      end
      if (state == COMPUTE) begin
         for (int i = 0; i < 4; i++) nextBoard[linePos(dirQ, cnt[1:0], 2'(i))] <= lineOut[i];
      end
   end

   always_comb begin
      for (int i = 0; i < 4; i++) lineIn[i] = snap[linePos(dirQ, cnt[1:0], 2'(i))];
   end

   line_merge #(
      .DATA_W  (DATA_W),
      .MAX_TILE(MAX_TILE),
      .SUM_W   (SUM_W)
   ) uMerge (
      .lineIn  (lineIn),
      .lineOut (lineOut),
      .mergeSum(mergeSum)
   );

   always_comb begin
      anyChanged = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (nextBoard[i] != snap[i]) anyChanged = 1'b1;
      end
   end

   always_comb begin
      bus.move_ready = (state == IDLE) && bus.mem_ready;
      bus.wr         = 1'b0;
      bus.addr_col   = '0;
      bus.addr_row   = '0;
      bus.data_out   = '0;
      bus.done       = 1'b0;
      bus.moved      = 1'b0;
      if (state == WRITE) begin
         bus.addr_col = cnt[3:2];
         bus.addr_row = cnt[1:0];
         bus.data_out = nextBoard[cnt];
`ifdef SKIP_UNCHANGED_EN
         bus.wr       = (nextBoard[cnt] != snap[cnt]);
`else
         bus.wr       = 1'b1;
`endif
      end
      if (state == DONE) begin
         bus.done  = 1'b1;
         bus.moved = anyChanged;
      end
   end

   assign bus.score = scoreQ;

endmodule

// File: tb/tb_board_move_writer.sv
// Scoreboard bench for board_move_writer: a reference slide/merge model predicts
// each move's writes, score and moved flag; DUT writes are queued and compared.
module tb_board_move_writer;

   localparam int SCORE_MAX = (1 << 20) - 1;

   logic clk;
   logic rst_n;

   board_move_writer_if bus ();

   board_move_writer dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks;
   int          passed;
   int          board [16];
   int          nb    [16];
   int          expScore;
   logic        expMoved;
   logic [15:0] expQ [$];
   logic [15:0] obsQ [$];

   function automatic int pos(input int dir, input int l, input int i);
      case (dir)
         0:       return l*4 + i;
         1:       return l*4 + (3 - i);
         2:       return i*4 + l;
         default: return (3 - i)*4 + l;
      endcase
   endfunction

   task automatic clear_board();
      for (int i = 0; i < 16; i++) board[i] = 0;
   endtask

   task automatic apply_board();
      for (int i = 0; i < 16; i++) bus.cells[i*12 +: 12] = 12'(board[i]);
   endtask

   // Reference model: walk the line with one pending tile.
   task automatic predict(input int dir);
      int ln [4];
      int res [4];
      int pend;
      int o;
      int sum;
      sum = 0;
      for (int l = 0; l < 4; l++) begin
         for (int i = 0; i < 4; i++) begin
            ln[i]  = board[pos(dir, l, i)];
            res[i] = 0;
         end
         pend = 0;
         o    = 0;
         for (int i = 0; i < 4; i++) begin
            if (ln[i] != 0) begin
               if (pend == 0) pend = ln[i];
               else if (pend == ln[i] && ln[i] != 2048) begin
                  res[o] = pend * 2; sum += pend * 2; o++; pend = 0;
               end else begin
                  res[o] = pend; o++; pend = ln[i];
               end
            end
         end
         if (pend != 0) res[o] = pend;
         for (int i = 0; i < 4; i++) nb[pos(dir, l, i)] = res[i];
      end
      expMoved = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (nb[i] != board[i]) expMoved = 1'b1;
`ifdef SKIP_UNCHANGED_EN
         if (nb[i] != board[i])
`endif
         expQ.push_back({4'(i), 12'(nb[i])});
      end
      expScore = (expScore + sum > SCORE_MAX) ? SCORE_MAX : expScore + sum;
   endtask

   task automatic run_move(input int dir, input bit holdValid, input bit scramble,
                           output int doneK, output logic movedObs);
      doneK    = -1;
      movedObs = 1'bx;
      @(negedge clk);
      bus.move_dir   = 2'(dir);
      bus.move_valid = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 1 && !holdValid) bus.move_valid = 1'b0;
         if (k == 2 && scramble) begin
            for (int i = 0; i < 16; i++) bus.cells[i*12 +: 12] = 12'($urandom_range(0, 4095));
         end
         if (bus.wr) obsQ.push_back({bus.addr_col, bus.addr_row, bus.data_out});
         if (bus.done) begin
            doneK          = k;
            movedObs       = bus.moved;
            bus.move_valid = 1'b0;
            break;
         end
      end
      bus.move_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n          = 1'b0;
      bus.mem_ready  = 1'b0;
      bus.move_valid = 1'b0;
      bus.move_dir   = 2'd0;
      bus.cells      = '0;
      expScore       = 0;
      repeat (2) @(negedge clk);
      checks++; if (bus.wr !== 1'b0 || bus.done !== 1'b0 || bus.moved !== 1'b0)
         $display("FAIL reset_strobes: wr=%b done=%b moved=%b required 0", bus.wr, bus.done, bus.moved);
      else passed++;
      checks++; if (bus.score !== 20'd0) $display("FAIL reset_score: got %0d required 0", bus.score);
      else passed++;
      checks++; if (bus.move_ready !== 1'b0) $display("FAIL reset_ready_gated: got %b required 0", bus.move_ready);
      else passed++;
      bus.mem_ready = 1'b1;
      #1;
      checks++; if (bus.move_ready !== 1'b1) $display("FAIL reset_ready: got %b required 1", bus.move_ready);
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      // No accept while memory is not ready.
      bus.mem_ready  = 1'b0;
      bus.move_valid = 1'b1;
      begin
         int act;
         act = 0;
         repeat (30) begin
            @(negedge clk);
            if (bus.wr || bus.done) act++;
         end
         checks++; if (act != 0) $display("FAIL mem_ready_gate: %0d active cycles, required 0", act);
         else passed++;
      end
      bus.move_valid = 1'b0;
      bus.mem_ready  = 1'b1;
   endtask

   task automatic test_left_merge();
      int   dk;
      logic mv;
      logic [15:0] e, o;
      clear_board();
      board[0] = 2; board[4] = 2; board[8] = 2; board[12] = 2;
      apply_board();
      predict(2);
      run_move(2, 1'b0, 1'b0, dk, mv);
      checks++; if (dk != 22) $display("FAIL left_done_cycle: got %0d required 22", dk); else passed++;
      checks++; if (mv !== 1'b1) $display("FAIL left_moved: got %b required 1", mv); else passed++;
      checks++; if (bus.score !== 20'd8) $display("FAIL left_score: got %0d required 8", bus.score); else passed++;
      while (expQ.size() != 0 && obsQ.size() != 0) begin
         e = expQ.pop_front(); o = obsQ.pop_front();
         checks++; if (o !== e) $display("FAIL left_write: got %h required %h", o, e); else passed++;
      end
      checks++; if (expQ.size() != 0 || obsQ.size() != 0)
         $display("FAIL left_write_count: unmatched expected=%0d observed=%0d", expQ.size(), obsQ.size());
      else passed++;
      expQ.delete(); obsQ.delete();
   endtask

   task automatic test_up_no_cascade();
      int   dk;
      logic mv;
      logic [15:0] e, o;
      clear_board();
      board[4] = 2; board[5] = 2; board[6] = 4;
      apply_board();
      predict(0);
      run_move(0, 1'b0, 1'b1, dk, mv);
      checks++; if (dk != 22) $display("FAIL up_done_cycle: got %0d required 22", dk); else passed++;
      checks++; if (bus.score !== 20'd12) $display("FAIL up_score: got %0d required 12", bus.score); else passed++;
      while (expQ.size() != 0 && obsQ.size() != 0) begin
         e = expQ.pop_front(); o = obsQ.pop_front();
         checks++; if (o !== e) $display("FAIL up_write: got %h required %h", o, e); else passed++;
      end
      checks++; if (expQ.size() != 0 || obsQ.size() != 0)
         $display("FAIL up_write_count: unmatched expected=%0d observed=%0d", expQ.size(), obsQ.size());
      else passed++;
      expQ.delete(); obsQ.delete();
   endtask

   task automatic test_right_busy();
      int   dk;
      int   act;
      logic mv;
      logic [15:0] e, o;
      clear_board();
      board[2] = 4; board[10] = 4; board[14] = 8;
      apply_board();
      predict(3);
      run_move(3, 1'b1, 1'b0, dk, mv);
      checks++; if (dk != 22) $display("FAIL right_done_cycle: got %0d required 22", dk); else passed++;
      checks++; if (mv !== 1'b1) $display("FAIL right_moved: got %b required 1", mv); else passed++;
      checks++; if (bus.score !== 20'd20) $display("FAIL right_score: got %0d required 20", bus.score); else passed++;
      while (expQ.size() != 0 && obsQ.size() != 0) begin
         e = expQ.pop_front(); o = obsQ.pop_front();
         checks++; if (o !== e) $display("FAIL right_write: got %h required %h", o, e); else passed++;
      end
      checks++; if (expQ.size() != 0 || obsQ.size() != 0)
         $display("FAIL right_write_count: unmatched expected=%0d observed=%0d", expQ.size(), obsQ.size());
      else passed++;
      expQ.delete(); obsQ.delete();
      act = 0;
      repeat (25) begin
         @(negedge clk);
         if (bus.wr || bus.done) act++;
      end
      checks++; if (act != 0) $display("FAIL busy_no_second_move: %0d active cycles, required 0", act);
      else passed++;
   endtask

   task automatic test_no_move();
      int   dk;
      logic mv;
      logic [15:0] e, o;
      clear_board();
      board[0] = 2; board[4] = 4; board[8] = 8; board[12] = 16;
      apply_board();
      predict(2);
      run_move(2, 1'b0, 1'b0, dk, mv);
      checks++; if (dk != 22) $display("FAIL nomove_done_cycle: got %0d required 22", dk); else passed++;
      checks++; if (mv !== 1'b0) $display("FAIL nomove_moved: got %b required 0", mv); else passed++;
      checks++; if (bus.score !== 20'd20) $display("FAIL nomove_score: got %0d required 20", bus.score); else passed++;
      while (expQ.size() != 0 && obsQ.size() != 0) begin
         e = expQ.pop_front(); o = obsQ.pop_front();
         checks++; if (o !== e) $display("FAIL nomove_write: got %h required %h", o, e); else passed++;
      end
      checks++; if (expQ.size() != 0 || obsQ.size() != 0)
         $display("FAIL nomove_write_count: unmatched expected=%0d observed=%0d", expQ.size(), obsQ.size());
      else passed++;
      expQ.delete(); obsQ.delete();
   endtask

   task automatic test_max_tile();
      int   dk;
      logic mv;
      logic [15:0] e, o;
      clear_board();
      board[0] = 2048; board[4] = 2048;
      apply_board();
      predict(2);
      run_move(2, 1'b0, 1'b0, dk, mv);
      checks++; if (mv !== 1'b0) $display("FAIL maxtile_moved: got %b required 0", mv); else passed++;
      checks++; if (bus.score !== 20'd20) $display("FAIL maxtile_score: got %0d required 20", bus.score); else passed++;
      while (expQ.size() != 0 && obsQ.size() != 0) begin
         e = expQ.pop_front(); o = obsQ.pop_front();
         checks++; if (o !== e) $display("FAIL maxtile_write: got %h required %h", o, e); else passed++;
      end
      checks++; if (expQ.size() != 0 || obsQ.size() != 0)
         $display("FAIL maxtile_write_count: unmatched expected=%0d observed=%0d", expQ.size(), obsQ.size());
      else passed++;
      expQ.delete(); obsQ.delete();
   endtask

   task automatic test_random();
      int   dk;
      int   dir;
      logic mv;
      logic [15:0] e, o;
      for (int t = 0; t < 8; t++) begin
         for (int i = 0; i < 16; i++)
            board[i] = ($urandom_range(0, 2) == 0) ? 0 : (1 << $urandom_range(1, 11));
         apply_board();
         dir = int'($urandom_range(0, 3));
         predict(dir);
         run_move(dir, 1'b0, 1'b0, dk, mv);
         checks++; if (mv !== expMoved) $display("FAIL rand_moved: got %b required %b", mv, expMoved); else passed++;
         checks++; if (bus.score !== 20'(expScore))
            $display("FAIL rand_score: got %0d required %0d", bus.score, expScore);
         else passed++;
         while (expQ.size() != 0 && obsQ.size() != 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front();
            checks++; if (o !== e) $display("FAIL rand_write: got %h required %h", o, e); else passed++;
         end
         checks++; if (expQ.size() != 0 || obsQ.size() != 0)
            $display("FAIL rand_write_count: unmatched expected=%0d observed=%0d", expQ.size(), obsQ.size());
         else passed++;
         expQ.delete(); obsQ.delete();
      end
   endtask

   task automatic test_reset_mid_write();
      clear_board();
      board[0] = 2; board[4] = 2; board[8] = 2; board[12] = 2;
      apply_board();
      @(negedge clk);
      bus.move_dir   = 2'd2;
      bus.move_valid = 1'b1;
      @(negedge clk);
      bus.move_valid = 1'b0;
      repeat (9) @(negedge clk);
      checks++; if (bus.wr !== 1'b1) $display("FAIL midwrite_active: wr=%b required 1", bus.wr); else passed++;
      rst_n = 1'b0;
      #1;
      checks++; if (bus.wr !== 1'b0 || bus.done !== 1'b0)
         $display("FAIL midwrite_reset_strobes: wr=%b done=%b required 0", bus.wr, bus.done);
      else passed++;
      checks++; if (bus.score !== 20'd0) $display("FAIL midwrite_reset_score: got %0d required 0", bus.score);
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      expScore = 0;
      @(negedge clk);
      checks++; if (bus.move_ready !== 1'b1) $display("FAIL midwrite_ready: got %b required 1", bus.move_ready);
      else passed++;
   endtask

   initial begin
      checks = 0;
      passed = 0;
      test_reset();
      test_left_merge();
      test_up_no_cascade();
      test_right_busy();
      test_no_move();
      test_max_tile();
      test_random();
      test_reset_mid_write();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
